// File: rtl/sigmoid_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sigmoid_seq : sequences an N-element vector through an external sigmoid unit.
// Optional feature macro: SIGSEQ_TIMEOUT_EN (WAIT watchdog + sticky err).
// Revision: 1.0
// ============================================================================
module sigmoid_seq #(
  parameter int S  = 32,
  parameter int N  = 4,
  parameter int TO = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [S-1:0] in_data,
  output logic         in_ready,
  output logic [S-1:0] act_x,
  output logic         act_start,
  input  logic [S-1:0] act_y,
  input  logic         act_done,
  output logic         out_valid,
  output logic [S-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy,
  output logic         err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [S-1:0]  mem [N];
  logic          wr_en;
  logic [S-1:0]  wr_data;
  logic          at_last;
  logic          tmo;

  assign at_last = (idx == LAST_IDX);

  generate
    if (N < 1 || TO < 1) begin : g_param_check
      $error("sigmoid_seq: N and TO must be at least 1");
    end
  endgenerate

`ifdef SIGSEQ_TIMEOUT_EN
  localparam int CW = $clog2(TO + 1);
  logic [CW-1:0] wait_cnt;
  logic          err_q;

  // Fires in the TO-th WAIT cycle, so the counter would reach TO on this edge.
  assign tmo = (state == WAIT) && !act_done && (wait_cnt == CW'(TO - 1));
  assign err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (tmo) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Buffer is deliberately left out of reset; results overwrite operands in place.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[idx] <= wr_data;
    end
  end

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    wr_en     = 1'b0;
    wr_data   = in_data;
    in_ready  = 1'b0;
    act_start = 1'b0;
    act_x     = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en = 1'b1;
          if (at_last) begin
            idx_nx   = '0;
            state_nx = ISSUE;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      ISSUE: begin
        busy      = 1'b1;
        act_start = 1'b1;
        act_x     = mem[idx];
        state_nx  = WAIT;
      end
      WAIT: begin
        busy  = 1'b1;
        act_x = mem[idx];
        if (act_done || tmo) begin
          wr_en   = 1'b1;
          wr_data = act_done ? act_y : '0;
          if (at_last) begin
            idx_nx   = '0;
            state_nx = DRAIN;
          end else begin
            idx_nx   = idx + 1'b1;
            state_nx = ISSUE;
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = mem[idx];
        out_last  = at_last;
        if (out_ready) begin
          if (at_last) begin
            idx_nx   = '0;
            state_nx = LOAD;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      default: state_nx = LOAD;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sigmoid_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_sigmoid_seq : randomized self-checking bench with a stub sigmoid responder
// (returns x+1) and a queue-based reference model. Revision: 1.0
// ============================================================================
module tb_sigmoid_seq;
  localparam int S  = 32;
  localparam int N  = 4;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [S-1:0] in_data = '0;
  logic         in_ready;
  logic [S-1:0] act_x;
  logic         act_start;
  logic [S-1:0] act_y = '0;
  logic         act_done = 1'b0;
  logic         out_valid;
  logic [S-1:0] out_data;
  logic         out_last;
  logic         out_ready = 1'b1;
  logic         busy;
  logic         err;

  always #5 clk = ~clk;

  sigmoid_seq #(.S(S), .N(N), .TO(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .act_x(act_x), .act_start(act_start), .act_y(act_y), .act_done(act_done),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Stub sigmoid unit: answers x+1 'lat' cycles after the start cycle.
  int          lat = 3;
  int          starts = 0;
  int          silent_elem = 0;
  logic        pend = 1'b0;
  int          rcnt = 0;
  logic [31:0] pval = '0;

  always @(posedge clk) begin
    act_done <= 1'b0;
    if (pend) begin
      if (rcnt <= 1) begin
        act_done <= 1'b1;
        act_y    <= pval;
        pend     <= 1'b0;
      end else begin
        rcnt <= rcnt - 1;
      end
    end
    if (act_start) begin
      starts <= starts + 1;
      if (starts + 1 != silent_elem) begin
        if (lat <= 1) begin
          act_done <= 1'b1;
          act_y    <= act_x + 32'd1;
        end else begin
          pend <= 1'b1;
          rcnt <= lat - 1;
          pval <= act_x + 32'd1;
        end
      end
    end
  end

  // Reference model: expected results in input order.
  typedef struct {
    logic [31:0] d;
    logic        last;
  } exp_t;
  exp_t exp_q[$];

  int busy_cyc   = 0;
  int stall_cyc  = 0;
  int stall_base = 0;
  int rdy_mode   = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cyc++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_output", exp_q.size(), 32'd1);
        end else begin
          check("out_data", out_data, exp_q[0].d);
          check("out_last", {31'd0, out_last}, {31'd0, exp_q[0].last});
          if (out_ready) void'(exp_q.pop_front());
          else stall_cyc++;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = !(out_valid && (N - exp_q.size()) == 1 && (stall_cyc - stall_base) < 5);
    endcase
  end

  task automatic load_vec(input logic [31:0] v [N], input bit gaps, input bit hold, input int zero_pos);
    int i = 0;
    int guard = 0;
    while (i < N && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end else begin
        in_valid = 1'b1;
        in_data  = v[i];
        if (in_ready) begin
          exp_q.push_back('{(i + 1 == zero_pos) ? 32'd0 : v[i] + 32'd1, i == N - 1});
          i++;
        end
      end
    end
    if (i < N) check("load_timeout", i, N);
    @(negedge clk);
    if (hold) begin
      in_valid = 1'b1;
      in_data  = 32'hdeadbeef;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    bit done = 1'b0;
    while (!done && g < 3000) begin
      @(negedge clk);
      g++;
      if (out_valid && out_last && out_ready) begin
        in_valid = 1'b0;
        done     = 1'b1;
      end
    end
    if (!done) check("drain_timeout", exp_q.size(), 32'd0);
    @(negedge clk);
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  logic [31:0] vec [N];
  logic [31:0] rv  [N];
  int s0, b0;

  initial begin
    vec = '{32'h40a00000, 32'h3f800000, 32'h00000000, 32'hbf800000};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_err",       {31'd0, err},       32'd0);
    check("rst_act_start", {31'd0, act_start}, 32'd0);
    check("rst_act_x",     act_x,    32'd0);
    check("rst_out_data",  out_data, 32'd0);
    rst = 1'b0;

    // Basic vector, fixed 3-cycle responder.
    lat = 3; rdy_mode = 0;
    load_vec(vec, 1'b0, 1'b0, 0);
    wait_drain();

    // Backpressure: 5 stalled cycles on the 2nd result.
    stall_base = stall_cyc; rdy_mode = 2;
    load_vec(vec, 1'b0, 1'b0, 0);
    wait_drain();
    check("stall_cycles", stall_cyc - stall_base, 32'd5);
    rdy_mode = 0;

    // Zero-latency responder: 2 cycles per element, 4 starts.
    lat = 1; s0 = starts; b0 = busy_cyc;
    load_vec(vec, 1'b0, 1'b0, 0);
    wait_drain();
    check("zl_busy_cycles", busy_cyc - b0, 32'd8);
    check("zl_starts", starts - s0, 32'd4);

    // Input gaps, in_valid held high with junk through compute and drain.
    lat = 2;
    foreach (rv[k]) rv[k] = $urandom;
    load_vec(rv, 1'b1, 1'b1, 0);
    wait_drain();

    // Reset during the 3rd element's WAIT.
    lat = 3; s0 = starts;
    foreach (rv[k]) rv[k] = $urandom;
    load_vec(rv, 1'b0, 1'b0, 0);
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (starts - s0 == 3 && busy && !act_start) break;
    end
    check("mid_wait_reached", starts - s0, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check("mr_in_ready",  {31'd0, in_ready},  32'd1);
    check("mr_out_valid", {31'd0, out_valid}, 32'd0);
    check("mr_busy",      {31'd0, busy},      32'd0);
    check("mr_act_x",     act_x, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("late_done_in_ready", {31'd0, in_ready}, 32'd1);
    check("late_done_busy",     {31'd0, busy},     32'd0);
    foreach (rv[k]) rv[k] = $urandom;
    load_vec(rv, 1'b0, 1'b0, 0);
    wait_drain();

    // Randomized vectors.
    rdy_mode = 1;
    for (int t = 0; t < 15; t++) begin
      lat = $urandom_range(1, 5);
      foreach (rv[k]) rv[k] = $urandom;
      load_vec(rv, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0);
      wait_drain();
    end
    rdy_mode = 0;

`ifdef SIGSEQ_TIMEOUT_EN
    // Element 2 never answered: watchdog zeroes it and raises err.
    lat = 2; silent_elem = starts + 2;
    check("tmo_err_before", {31'd0, err}, 32'd0);
    load_vec(vec, 1'b0, 1'b0, 2);
    wait_drain();
    check("tmo_err_after", {31'd0, err}, 32'd1);
    silent_elem = 0;
`else
    check("err_tied_low", {31'd0, err}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
